multi_channel_watchdog: RTL
===========================

# multi_channel_watchdog

Parametrised, multi-channel windowed watchdog for the AM radio FPGA supervisor. Each channel independently monitors a heartbeat from one firmware or datapath task, flags a warning before expiry, and latches a sticky trigger on timeout or on a too-early heartbeat. Any new channel trigger raises a stretched system reset request consumed by the board reset controller.

## Interface
Parameters:
- N_CH, 4: number of monitored channels (1..16)
- CNT_W, 32: per-channel counter width
- TIMEOUT, 1000000: cycles without heartbeat before trigger
- WARN_AT, 750000: counter value at which warning asserts
- WINDOW_MIN, 0: heartbeat with counter < WINDOW_MIN is an early fault; 0 disables window checking
- RST_PULSE, 16: sys_reset_req pulse length in cycles (>=1)

Ports:
- clk  in  1  system clock; single clock domain
- rstn  in  1  asynchronous, active-low reset
- enable  in  N_CH  per-channel enable, level
- heartbeat  in  N_CH  per-channel kick, sampled each rising edge
- force_reset  in  1  forces every enabled channel to TRIGGERED
- clear  in  N_CH  per-channel acknowledge of a latched trigger
- warning  out  N_CH  counter in warning band
- triggered  out  N_CH  sticky trigger
- early_fault  out  N_CH  sticky; trigger cause was an early heartbeat
- any_triggered  out  1  OR of triggered
- sys_reset_req  out  1  stretched reset request

## Operation
- Reset (rstn low): all channels IDLE, counters 0, every output 0, pulse counter 0. Registers update asynchronously on rstn falling edge.
- Elaboration check: WINDOW_MIN < WARN_AT < TIMEOUT <= 2^CNT_W-1; violation is a fatal elaboration error.
- Per-channel states: IDLE, RUN, WARN, TRIGGERED.
- IDLE: counter held 0. enable=1 -> RUN, counter 0.
- RUN/WARN: counter increments by 1 per cycle. heartbeat=1 with counter >= WINDOW_MIN -> RUN, counter 0. heartbeat=1 with counter < WINDOW_MIN (WINDOW_MIN>0) -> TRIGGERED, early_fault=1. counter reaching WARN_AT -> WARN. No heartbeat with counter == TIMEOUT-1 -> TRIGGERED. enable=0 -> IDLE, counter 0.
- TRIGGERED: counter frozen; enable ignored. clear=1 -> IDLE (re-arms to RUN next cycle if enable=1); clears triggered and early_fault.
- force_reset=1: every channel in RUN or WARN -> TRIGGERED (early_fault unchanged, 0). IDLE channels unaffected.
- Priority per channel per cycle: rstn > force_reset > enable=0 > heartbeat > timeout. Heartbeat on the timeout cycle services the channel. In TRIGGERED, clear is applied only if no force_reset that cycle.
- warning = (state == WARN); triggered = (state == TRIGGERED); all outputs registered.
- Reset stretcher: on any edge where at least one channel enters TRIGGERED, load pulse counter with RST_PULSE; sys_reset_req = (pulse counter != 0); decrement to 0. A new entry during a pulse reloads (extends). Channels already TRIGGERED do not retrigger the pulse.

## Timing
- Edge E0 samples enable=1 in IDLE; counter=k after edge Ek. Without heartbeat, warning is high after edge E_WARN_AT, triggered high after edge E_TIMEOUT.
- Heartbeat sampled at edge Ek -> counter 0 after Ek, warning low after Ek.
- sys_reset_req and any_triggered rise on the same edge as the first triggered bit; sys_reset_req stays high exactly RST_PULSE cycles.
- clear at edge Ek -> triggered low after Ek; RUN with counter 0 after Ek+1 if enable held.
- rstn deassertion: first state change possible on the first edge after release.

## Structure
- Package wd_pkg: wd_state_t enum (IDLE, RUN, WARN, TRIGGERED), parameter-legality function.
- Sub-module wd_channel: one channel FSM plus counter, outputs state flags and an "entered TRIGGERED" strobe; top generates N_CH instances and holds the reset stretcher and OR reduction.

## Test plan
Config N_CH=2, CNT_W=8, TIMEOUT=10, WARN_AT=7, WINDOW_MIN=2, RST_PULSE=4.
- ch0 enable, no heartbeat -> warning[0] high after E7, triggered[0] and sys_reset_req high after E10, sys_reset_req low after 4 cycles, triggered[0] stays high.
- ch0 heartbeat every 5 cycles for 100 cycles -> warning, triggered, sys_reset_req never assert.
- ch1 heartbeat at counter=1 -> triggered[1] and early_fault[1] high next edge; clear[1] -> both low, ch1 re-arms with counter 0.
- ch0 triggers at E10, ch1 triggers 2 cycles later -> sys_reset_req extended, high 6 cycles total; heartbeat on timeout cycle instead -> no trigger.
- force_reset with ch0 RUN, ch1 IDLE -> triggered=2'b01; enable[0] dropped afterwards -> triggered[0] stays 1.
- rstn low mid-WARN -> all outputs 0 immediately, counters 0, IDLE after release.

Source files
------------

// File: rtl/wd_pkg.sv
// Shared types and parameter checks for the multi-channel watchdog.
`timescale 1ns/1ps
package wd_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    WARN      = 2'd2,
    TRIGGERED = 2'd3
  } wd_state_t;

  // Legal when WINDOW_MIN < WARN_AT < TIMEOUT <= 2^CNT_W-1.
  function automatic bit wd_params_ok(input int unsigned     cnt_w,
                                      input longint unsigned timeout,
                                      input longint unsigned warn_at,
                                      input longint unsigned window_min);
    longint unsigned cnt_max;
    cnt_max = (cnt_w >= 64) ? '1 : ((64'd1 << cnt_w) - 64'd1);
    return (window_min < warn_at) && (warn_at < timeout) && (timeout <= cnt_max);
  endfunction

endpackage

// File: rtl/wd_channel.sv
// One watchdog channel: state machine, cycle counter and a strobe that is
// high in the cycle whose clock edge moves the channel into TRIGGERED.
`timescale 1ns/1ps
module wd_channel
  import wd_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned TIMEOUT    = 1000000,
  parameter int unsigned WARN_AT    = 750000,
  parameter int unsigned WINDOW_MIN = 0
) (
  input  logic clk,
  input  logic rstn,
  input  logic enable,
  input  logic heartbeat,
  input  logic force_reset,
  input  logic clear,
  output logic warning,
  output logic triggered,
  output logic early_fault,
  output logic enter_trig
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WARN_V   = CNT_W'(WARN_AT);

  wd_state_t        state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             early_reg;

  logic             active;
  logic             too_early;
  logic             early_hit;
  logic [CNT_W-1:0] cnt_inc;

  generate
    if (WINDOW_MIN > 0) begin : g_window
      localparam logic [CNT_W-1:0] WMIN_V = CNT_W'(WINDOW_MIN);
      assign too_early = (cnt_reg < WMIN_V);
    end else begin : g_no_window
      assign too_early = 1'b0;
    end
  endgenerate

  // Force outranks a disable, which outranks a heartbeat, which outranks timeout.
  assign active     = (state_reg == RUN) || (state_reg == WARN);
  assign early_hit  = active && !force_reset && enable && heartbeat && too_early;
  assign enter_trig = active && (force_reset || early_hit ||
                                 (enable && !heartbeat && (cnt_reg == CNT_LAST)));
  assign cnt_inc    = cnt_reg + CNT_W'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      early_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (enable) state_reg <= RUN;
        end
        RUN, WARN: begin
          if (enter_trig) begin
            state_reg <= TRIGGERED;
            early_reg <= early_hit;
          end else if (!enable) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (heartbeat) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
          end else begin
            cnt_reg   <= cnt_inc;
            state_reg <= (cnt_inc >= WARN_V) ? WARN : RUN;
          end
        end
        TRIGGERED: begin
          if (!force_reset && clear) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            early_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign warning     = (state_reg == WARN);
  assign triggered   = (state_reg == TRIGGERED);
  assign early_fault = early_reg;

endmodule

// File: rtl/multi_channel_watchdog.sv
// N_CH independent windowed watchdogs plus a stretched system reset request
// that fires whenever any channel newly enters TRIGGERED.
`timescale 1ns/1ps
module multi_channel_watchdog
  import wd_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned TIMEOUT    = 1000000,
  parameter int unsigned WARN_AT    = 750000,
  parameter int unsigned WINDOW_MIN = 0,
  parameter int unsigned RST_PULSE  = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N_CH-1:0] enable,
  input  logic [N_CH-1:0] heartbeat,
  input  logic            force_reset,
  input  logic [N_CH-1:0] clear,
  output logic [N_CH-1:0] warning,
  output logic [N_CH-1:0] triggered,
  output logic [N_CH-1:0] early_fault,
  output logic            any_triggered,
  output logic            sys_reset_req
);

  localparam int unsigned PW = $clog2(RST_PULSE + 1);

  generate
    if (!wd_params_ok(CNT_W, TIMEOUT, WARN_AT, WINDOW_MIN) ||
        (RST_PULSE < 1) || (N_CH < 1) || (N_CH > 16)) begin : g_bad_params
      $fatal(1, "multi_channel_watchdog: illegal parameter combination");
    end
  endgenerate

  logic [N_CH-1:0] enter_vec;
  logic [PW-1:0]   pulse_reg;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      wd_channel #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .WARN_AT    (WARN_AT),
        .WINDOW_MIN (WINDOW_MIN)
      ) u_ch (
        .clk         (clk),
        .rstn        (rstn),
        .enable      (enable[gi]),
        .heartbeat   (heartbeat[gi]),
        .force_reset (force_reset),
        .clear       (clear[gi]),
        .warning     (warning[gi]),
        .triggered   (triggered[gi]),
        .early_fault (early_fault[gi]),
        .enter_trig  (enter_vec[gi])
      );
    end
  endgenerate

  // A fresh trigger reloads the stretcher, so overlapping faults extend the pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pulse_reg <= '0;
    end else if (|enter_vec) begin
      pulse_reg <= PW'(RST_PULSE);
    end else if (pulse_reg != '0) begin
      pulse_reg <= pulse_reg - PW'(1);
    end
  end

  assign sys_reset_req = |pulse_reg;
  assign any_triggered = |triggered;

endmodule
